// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 1 start bit, NrOfDataBits data bits
// LSB first, 1 stop bit, no parity. The line is sampled in the middle of each
// bit. A received character is presented on dataBits with a one-cycle
// dataValid strobe. A frame whose stop bit is low gives a one-cycle frameError
// strobe instead.
module uart_rx #(
  parameter int ClockFrequency = 24_000_000,
  parameter int BaudRate       = 9600,
  parameter int NrOfDataBits   = 8
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic                    rx,
  output logic [NrOfDataBits-1:0] dataBits,
  output logic                    dataValid,
  output logic                    frameError,
  output logic                    busy
);

  localparam int DIVISOR = ClockFrequency / BaudRate;
  localparam int HALF    = DIVISOR / 2;
  localparam int BAUD_W  = $clog2(DIVISOR);
  localparam int BIT_W   = $clog2(NrOfDataBits + 1);

  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF - 1);
  localparam logic [BAUD_W-1:0] DIV_LAST  = BAUD_W'(DIVISOR - 1);
  localparam logic [BIT_W-1:0]  BITS_LAST = BIT_W'(NrOfDataBits - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic [2:0]              state_q, state_d;
  logic                    rx_meta_q, rx_meta_d;
  logic                    rxs_q, rxs_d;
  logic [BAUD_W-1:0]       baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [NrOfDataBits-1:0] shift_q, shift_d;
  logic [NrOfDataBits-1:0] data_bits_q, data_bits_d;
  logic                    data_valid_q, data_valid_d;
  logic                    frame_error_q, frame_error_d;

  // Next-state logic: the synchronizer, bit timing and the receive FSM.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    rx_meta_d     = rx;
    rxs_d         = rx_meta_q;
    state_d       = state_q;
    baud_cnt_d    = baud_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    data_bits_d   = data_bits_q;
    data_valid_d  = 1'b0;
    frame_error_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rxs_q) begin
          state_d    = ST_START;
          baud_cnt_d = '0;
        end
      end
      ST_START: begin
        if (baud_cnt_q == HALF_LAST) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          // A line that is high again by mid start bit was a glitch.
          state_d    = rxs_q ? ST_IDLE : ST_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_cnt_q == DIV_LAST) begin
          baud_cnt_d = '0;
          shift_d    = {rxs_q, shift_q[NrOfDataBits-1:1]};
          bit_cnt_d  = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BITS_LAST) begin
            state_d = ST_STOP;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_cnt_q == DIV_LAST) begin
          baud_cnt_d = '0;
          if (rxs_q) begin
            // Leave at mid stop bit so a start bit that follows with no
            // idle gap is still caught.
            data_bits_d  = shift_q;
            data_valid_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = ST_BREAK;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end
      ST_BREAK: begin
        // Wait out a held-low line so it cannot look like a new start bit.
        if (rxs_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its value from before the edge.
    if (!resetN) begin
      // NOTE: the synchronizer resets to the idle line level (1), otherwise
      // leaving reset would look like a start bit.
      rx_meta_q     <= 1'b1;
      rxs_q         <= 1'b1;
      state_q       <= ST_IDLE;
      baud_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      data_bits_q   <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      rx_meta_q     <= rx_meta_d;
      rxs_q         <= rxs_d;
      state_q       <= state_d;
      baud_cnt_q    <= baud_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      data_bits_q   <= data_bits_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign dataBits   = data_bits_q;
  assign dataValid  = data_valid_q;
  assign frameError = frame_error_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into an 8-bit and a 7-bit receiver.
// The bench predicts every strobe (cycle, kind, data) from the frame timing
// rules. It then compares the predictions with the strobes it observed.
module tb_uart_rx;

  localparam int DIV  = 16;   // 1600 Hz / 100 baud
  localparam int HALF = 8;
  // The pin changes just after edge E. It passes through two synchronizer
  // edges, and the FSM first acts on it at edge t0 = E + 3.
  localparam int SYNC = 3;

  typedef struct {
    int         cyc;
    int         kind;   // 0 = dataValid, 1 = frameError
    logic [8:0] data;
  } ev_t;

  logic       clock = 1'b0;
  logic       resetN;
  logic       rx8, rx7;
  logic [7:0] db8;
  logic [6:0] db7;
  logic       v8, fe8, busy8, v7, fe7, busy7;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  ev_t  exp8[$], got8[$], exp7[$], got7[$];
  logic [8:0] last8 = '0, last7 = '0;

  uart_rx #(.ClockFrequency(1600), .BaudRate(100), .NrOfDataBits(8)) dut8 (
    .clock(clock), .resetN(resetN), .rx(rx8), .dataBits(db8),
    .dataValid(v8), .frameError(fe8), .busy(busy8)
  );

  uart_rx #(.ClockFrequency(1600), .BaudRate(100), .NrOfDataBits(7)) dut7 (
    .clock(clock), .resetN(resetN), .rx(rx7), .dataBits(db7),
    .dataValid(v7), .frameError(fe7), .busy(busy7)
  );

  always #5 clock = ~clock;

  // Count rising edges so that strobes can be time-stamped.
  always @(posedge clock) cyc <= cyc + 1;

  // Record every strobe on the falling edge. The stamp is the edge that set it.
  always @(negedge clock) begin
    if (v8)  got8.push_back('{cyc, 0, {1'b0, db8}});
    if (fe8) got8.push_back('{cyc, 1, {1'b0, db8}});
    if (v7)  got7.push_back('{cyc, 0, {2'b0, db7}});
    if (fe7) got7.push_back('{cyc, 1, {2'b0, db7}});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold a line level for n bit-clocks. Each call starts and ends 1 time unit
  // after a rising edge.
  task automatic drive(input int which, input logic v, input int n);
    if (which == 8) rx8 = v;
    else            rx7 = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic at_neg(input int n);
    do @(negedge clock); while (cyc < n);
  endtask

  // Send one frame and record the strobe the frame timing predicts.
  task automatic send_frame(input int which, input logic [8:0] data,
                            input logic stop_ok, input int low_extra);
    int   nb;
    int   e;
    ev_t  ev;
    logic [8:0] d;
    nb = (which == 8) ? 8 : 7;
    d  = data & 9'((1 << nb) - 1);
    e  = cyc;
    drive(which, 1'b0, DIV);
    for (int i = 0; i < nb; i++) drive(which, d[i], DIV);
    drive(which, stop_ok, DIV + (stop_ok ? 0 : low_extra));
    ev.cyc  = e + SYNC + HALF + (nb + 1) * DIV;
    ev.kind = stop_ok ? 0 : 1;
    if (which == 8) begin
      if (stop_ok) last8 = d;
      ev.data = last8;
      exp8.push_back(ev);
    end else begin
      if (stop_ok) last7 = d;
      ev.data = last7;
      exp7.push_back(ev);
    end
  endtask

  task automatic compare(input string name, input ev_t exp_q[$], input ev_t got_q[$]);
    int n;
    check({name, ".count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d].cyc", name, i),  got_q[i].cyc,  exp_q[i].cyc);
      check($sformatf("%s[%0d].kind", name, i), got_q[i].kind, exp_q[i].kind);
      check($sformatf("%s[%0d].data", name, i), got_q[i].data, exp_q[i].data);
    end
  endtask

  initial begin
    int e;
    int h;
    logic [7:0] bits5a;
    bits5a = 8'h5A;

    // Reset state
    resetN = 1'b0;
    rx8    = 1'b1;
    rx7    = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst.db8", db8, 0);
    check("rst.v8", v8, 0);
    check("rst.fe8", fe8, 0);
    check("rst.busy8", busy8, 0);
    check("rst.db7", db7, 0);
    check("rst.busy7", busy7, 0);
    resetN = 1'b1;
    drive(8, 1'b1, 10);

    // Single good frame 0xA5
    send_frame(8, 9'hA5, 1'b1, 0);
    drive(8, 1'b1, 20);
    check("a5.busy_after", busy8, 0);
    check("a5.db8", db8, 8'hA5);

    // Glitch: low for 4 clocks. START is entered at e+3 and abandoned at e+11.
    e   = cyc;
    rx8 = 1'b0;
    at_neg(e + 2);
    check("glitch.busy_pre_t0", busy8, 0);
    at_neg(e + 3);
    check("glitch.busy_t0", busy8, 1);
    @(posedge clock);
    #1;
    rx8 = 1'b1;
    at_neg(e + 10);
    check("glitch.busy_last", busy8, 1);
    at_neg(e + 11);
    check("glitch.busy_drop", busy8, 0);
    check("glitch.db8_kept", db8, 8'hA5);
    @(posedge clock);
    #1;
    drive(8, 1'b1, 20);

    // Frame 0x3C with a low stop bit, line held low 40 more clocks
    send_frame(8, 9'h3C, 1'b0, 40);
    check("brk.busy_low", busy8, 1);
    h   = cyc;
    rx8 = 1'b1;
    at_neg(h + 2);
    check("brk.busy_hold", busy8, 1);
    at_neg(h + 3);
    check("brk.busy_drop", busy8, 0);
    check("brk.db8_kept", db8, 8'hA5);
    @(posedge clock);
    #1;
    drive(8, 1'b1, 20);

    // Back-to-back 0x00 then 0xFF with no idle gap
    send_frame(8, 9'h00, 1'b1, 0);
    send_frame(8, 9'hFF, 1'b1, 0);
    drive(8, 1'b1, 20);

    // Reset during data bit 3 of 0x5A
    drive(8, 1'b0, DIV);
    for (int i = 0; i < 3; i++) drive(8, bits5a[i], DIV);
    drive(8, bits5a[3], DIV / 2);
    check("midrst.busy_before", busy8, 1);
    resetN = 1'b0;
    @(posedge clock);
    #1;
    resetN = 1'b1;
    rx8    = 1'b1;
    @(negedge clock);
    check("midrst.db8", db8, 0);
    check("midrst.v8", v8, 0);
    check("midrst.fe8", fe8, 0);
    check("midrst.busy8", busy8, 0);
    last8 = '0;
    last7 = '0;
    @(posedge clock);
    #1;
    drive(8, 1'b1, 40);
    send_frame(8, 9'h81, 1'b1, 0);
    drive(8, 1'b1, 20);

    // 7-bit receiver, frame 0x55
    send_frame(7, 9'h55, 1'b1, 0);
    drive(7, 1'b1, 20);
    check("n7.db7", db7, 7'h55);

    // Random frames: random data, gaps and occasional framing errors
    for (int k = 0; k < 16; k++) begin
      int   w;
      logic ok;
      w  = (k < 10) ? 8 : 7;
      ok = ($urandom_range(0, 3) != 0);
      send_frame(w, 9'($urandom_range(0, 511)), ok, $urandom_range(0, 30));
      drive(w, 1'b1, ok ? $urandom_range(0, 30) : $urandom_range(2, 30));
    end

    drive(8, 1'b1, 60);
    compare("ev8", exp8, got8);
    compare("ev7", exp7, got7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
